// File: rtl/snake_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg
// Shared constants for the snake game sequencer and the snake drawing block:
//   dir_t      - movement direction codes (IDLE/UP/DOWN/LEFT/RIGHT)
//   gstate_t   - game state codes (IDLE/PLAY/PAUSE/GAME_OVER)
//   COL_*      - collision codes reported by the drawing block
//   opposite() - returns the reverse of a direction (IDLE maps to IDLE)
// ---------------------------------------------------------------------------
package snake_pkg;

  typedef enum logic [2:0] {
    DIR_IDLE  = 3'b000,
    DIR_UP    = 3'b001,
    DIR_DOWN  = 3'b010,
    DIR_LEFT  = 3'b011,
    DIR_RIGHT = 3'b100
  } dir_t;

  typedef enum logic [1:0] {
    GS_IDLE      = 2'b00,
    GS_PLAY      = 2'b01,
    GS_PAUSE     = 2'b10,
    GS_GAME_OVER = 2'b11
  } gstate_t;

  // Code 11 is reserved and behaves like COL_NONE.
  localparam logic [1:0] COL_NONE  = 2'b00;
  localparam logic [1:0] COL_HIT   = 2'b01;
  localparam logic [1:0] COL_APPLE = 2'b10;

  function automatic dir_t opposite(input dir_t d);
    dir_t r;
    case (d)
      DIR_UP:    r = DIR_DOWN;
      DIR_DOWN:  r = DIR_UP;
      DIR_LEFT:  r = DIR_RIGHT;
      DIR_RIGHT: r = DIR_LEFT;
      default:   r = DIR_IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snake_dir_arbiter.sv
// ---------------------------------------------------------------------------
// snake_dir_arbiter
// Turns debounced direction buttons into a pending direction for the next
// movement step.
//   clk, reset            - clock, synchronous active-high reset
//   btn_up/down/left/right- button levels (rising edges act, once per press)
//   accept_en             - presses are only taken while high (game in PLAY)
//   load_right            - game start: pending and committed forced to RIGHT
//   commit                - movement step: pending becomes the committed dir
//   pending_dir           - direction to be applied at the next step
// Simultaneous rises resolve UP>DOWN>LEFT>RIGHT first; the winner is then
// dropped if it would reverse the snake onto itself.
// ---------------------------------------------------------------------------
module snake_dir_arbiter
  import snake_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic accept_en,
  input  logic load_right,
  input  logic commit,
  output dir_t pending_dir
);

  logic [3:0] btn_now;
  logic [3:0] btn_q;
  logic [3:0] btn_d;
  logic [3:0] btn_rise;
  dir_t       pending_q, pending_d;
  dir_t       committed_q, committed_d;
  dir_t       pick;
  dir_t       committed_eff;

  assign btn_now  = {btn_up, btn_down, btn_left, btn_right};
  assign btn_d    = btn_now;
  assign btn_rise = btn_now & ~btn_q;

  always_comb begin
    pick = DIR_IDLE;
    if (btn_rise[3])      pick = DIR_UP;
    else if (btn_rise[2]) pick = DIR_DOWN;
    else if (btn_rise[1]) pick = DIR_LEFT;
    else if (btn_rise[0]) pick = DIR_RIGHT;
  end

  // A press landing on the commit cycle is judged against the direction
  // that is being committed right now, not the one it replaces.
  assign committed_eff = commit ? pending_q : committed_q;

  always_comb begin
    pending_d   = pending_q;
    committed_d = committed_q;
    if (load_right) begin
      pending_d   = DIR_RIGHT;
      committed_d = DIR_RIGHT;
    end else begin
      if (commit) committed_d = pending_q;
      if (accept_en && (pick != DIR_IDLE) && (pick != opposite(committed_eff)))
        pending_d = pick;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q       <= 4'b0000;
      pending_q   <= DIR_RIGHT;
      committed_q <= DIR_IDLE;
    end else begin
      btn_q       <= btn_d;
      pending_q   <= pending_d;
      committed_q <= committed_d;
    end
  end

  assign pending_dir = pending_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// ---------------------------------------------------------------------------
// snake_game_ctrl
// Game sequencer for the snake datapath: IDLE/PLAY/GAME_OVER state machine,
// frame-paced movement tick, direction commit, scoring and speed-up.
//   clk, reset         - pixel clock, synchronous active-high reset
//   frame_start        - one-cycle pulse per frame
//   btn_up/down/left/right/start - debounced button levels
//   collision[1:0]     - 00 none, 01 hit, 10 apple, 11 treated as none
//   update             - one-cycle move strobe to the drawing block
//   direction[2:0]     - committed direction (000 outside PLAY/PAUSE)
//   game_state[1:0]    - 00 IDLE, 01 PLAY, 10 PAUSE, 11 GAME_OVER
//   score[7:0]         - apples this game, saturating at 255
// Optional build macro SNAKE_PAUSE_EN: btn_start toggles PLAY <-> PAUSE.
// Without it btn_start is ignored during PLAY and PAUSE is never entered.
// ---------------------------------------------------------------------------
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_FRAMES        = 8,
  parameter int MIN_FRAMES         = 3,
  parameter int APPLES_PER_SPEEDUP = 4,
  parameter int GAMEOVER_FRAMES    = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  input  logic [1:0] collision,
  output logic       update,
  output logic [2:0] direction,
  output logic [1:0] game_state,
  output logic [7:0] score
);

  // One frame counter serves both the movement tick and the GAME_OVER hold.
  localparam int CNT_MAX = (GAMEOVER_FRAMES > TICK_FRAMES) ? GAMEOVER_FRAMES : TICK_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int APL_W   = $clog2(APPLES_PER_SPEEDUP + 1);

  gstate_t            state_q, state_d;
  dir_t               direction_q, direction_d;
  logic               update_q, update_d;
  logic [7:0]         score_q, score_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [APL_W-1:0]   apple_cnt_q, apple_cnt_d;
  logic               start_q, start_d;
  logic               apple_q, apple_d;

  logic               start_rise;
  logic               apple_rise;
  logic               hit;
  logic               accept_en;
  logic               load_right;
  logic               commit;
  dir_t               pending_dir;

  assign start_d    = btn_start;
  assign apple_d    = (collision == COL_APPLE);
  assign start_rise = btn_start & ~start_q;
  assign apple_rise = apple_d & ~apple_q;
  assign hit        = (collision == COL_HIT);

  snake_dir_arbiter u_dir_arbiter (
    .clk         (clk),
    .reset       (reset),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .accept_en   (accept_en),
    .load_right  (load_right),
    .commit      (commit),
    .pending_dir (pending_dir)
  );

  always_comb begin
    state_d     = state_q;
    direction_d = direction_q;
    update_d    = 1'b0;
    score_d     = score_q;
    frame_cnt_d = frame_cnt_q;
    period_d    = period_q;
    apple_cnt_d = apple_cnt_q;
    accept_en   = 1'b0;
    load_right  = 1'b0;
    commit      = 1'b0;

    case (state_q)
      GS_IDLE: begin
        direction_d = DIR_IDLE;
        if (start_rise) begin
          state_d     = GS_PLAY;
          score_d     = 8'd0;
          period_d    = CNT_W'(TICK_FRAMES);
          frame_cnt_d = '0;
          apple_cnt_d = '0;
          direction_d = DIR_RIGHT;
          load_right  = 1'b1;
        end
      end

      GS_PLAY: begin
        accept_en = 1'b1;

        // Apples still score on the cycle a hit ends the game.
        if (apple_rise) begin
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
          if (apple_cnt_q == APL_W'(APPLES_PER_SPEEDUP - 1)) begin
            apple_cnt_d = '0;
            if (period_q > CNT_W'(MIN_FRAMES)) period_d = period_q - 1'b1;
          end else begin
            apple_cnt_d = apple_cnt_q + 1'b1;
          end
        end

        if (hit) begin
          // Game over beats any tick due this cycle.
          state_d     = GS_GAME_OVER;
          frame_cnt_d = '0;
          direction_d = DIR_IDLE;
`ifdef SNAKE_PAUSE_EN
        end else if (start_rise) begin
          state_d = GS_PAUSE;
`endif
        end else if (frame_start) begin
          // >= rather than == so a period shrinking below the running
          // count fires on the next frame instead of wrapping.
          if (frame_cnt_q >= (period_q - 1'b1)) begin
            frame_cnt_d = '0;
            update_d    = 1'b1;
            direction_d = pending_dir;
            commit      = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end

`ifdef SNAKE_PAUSE_EN
      GS_PAUSE: begin
        // Counter, direction and score are frozen; only btn_start acts.
        if (start_rise) state_d = GS_PLAY;
      end
`endif

      GS_GAME_OVER: begin
        direction_d = DIR_IDLE;
        if (frame_start) begin
          if (frame_cnt_q == CNT_W'(GAMEOVER_FRAMES - 1)) begin
            state_d     = GS_IDLE;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d     = GS_IDLE;
        direction_d = DIR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= GS_IDLE;
      direction_q <= DIR_IDLE;
      update_q    <= 1'b0;
      score_q     <= 8'd0;
      frame_cnt_q <= '0;
      period_q    <= CNT_W'(TICK_FRAMES);
      apple_cnt_q <= '0;
      start_q     <= 1'b0;
      apple_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      direction_q <= direction_d;
      update_q    <= update_d;
      score_q     <= score_d;
      frame_cnt_q <= frame_cnt_d;
      period_q    <= period_d;
      apple_cnt_q <= apple_cnt_d;
      start_q     <= start_d;
      apple_q     <= apple_d;
    end
  end

  assign update     = update_q;
  assign direction  = direction_q;
  assign game_state = state_q;
  assign score      = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snake_game_ctrl
// Directed bench for snake_game_ctrl. Each expected move strobe (frame number
// it follows, direction) is queued when the stimulus is planned; a monitor
// pops and compares on every update pulse. State/score values are checked
// directly at fixed points. Pause behaviour is covered when SNAKE_PAUSE_EN
// is defined; otherwise btn_start in PLAY is checked to be ignored.
// ---------------------------------------------------------------------------
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       btn_up, btn_down, btn_left, btn_right, btn_start;
  logic [1:0] collision;
  logic       update;
  logic [2:0] direction;
  logic [1:0] game_state;
  logic [7:0] score;

  typedef struct packed {
    int         fs;
    logic [2:0] dir;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   fs_count = 0;
  int   cyc      = 0;
  int   last_fs_cyc = -10;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  snake_game_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_start   (btn_start),
    .collision   (collision),
    .update      (update),
    .direction   (direction),
    .game_state  (game_state),
    .score       (score)
  );

  // Scoreboard monitor: every update pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (update) begin
      exp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL update_unexpected frame=%0d dir=%0d required no update", fs_count, direction);
      end else begin
        e = exp_q.pop_front();
        if (e.fs == fs_count && e.dir == direction && (cyc - last_fs_cyc) == 1) begin
          n_pass++;
          $display("update frame=%0d dir=%0d latency=%0d ok", fs_count, direction, cyc - last_fs_cyc);
        end else begin
          $display("FAIL update_match frame=%0d dir=%0d latency=%0d required frame=%0d dir=%0d latency=1",
                   fs_count, direction, cyc - last_fs_cyc, e.fs, e.dir);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) begin
      n_pass++;
      $display("check %s = %0d ok", name, act);
    end else begin
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int fs, input logic [2:0] dir);
    exp_t e;
    e.fs  = fs;
    e.dir = dir;
    exp_q.push_back(e);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      fs_count++;
      last_fs_cyc = cyc;
      step();
      frame_start = 1'b0;
      step(3);
    end
  endtask

  task automatic apples(input int n);
    for (int i = 0; i < n; i++) begin
      collision = 2'b10;
      step(3);
      collision = 2'b00;
      step();
    end
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frame_start = 1'b0; collision = 2'b00;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_start = 1'b0;
    step(3);
    chk("reset_state", game_state, 0);
    chk("reset_dir", direction, 0);
    chk("reset_update", update, 0);
    chk("reset_score", score, 0);
    reset = 1'b0;
    step(2);

    // Start: PLAY one cycle after the press, heading RIGHT.
    press_start();
    chk("start_state", game_state, 1);
    chk("start_dir", direction, 4);
    chk("start_score", score, 0);
    step();
    push_exp(8, 3'd4);
    frames(8);

    // LEFT is a reversal (rejected); UP+DOWN together -> UP wins.
    btn_left = 1'b1; step(); btn_left = 1'b0; step();
    btn_up = 1'b1; btn_down = 1'b1; step(); btn_up = 1'b0; btn_down = 1'b0; step();
    push_exp(16, 3'd1);
    frames(8);
    chk("dir_after_up", direction, 1);

    // 4 apples -> period 7.
    apples(4);
    chk("score_4", score, 4);
    push_exp(23, 3'd1);
    push_exp(30, 3'd1);
    frames(14);

    // 20 apples total -> period floors at 3.
    apples(16);
    chk("score_20", score, 20);
    push_exp(33, 3'd1);
    push_exp(36, 3'd1);
    frames(6);

    // 300 apples total -> saturated score, period still 3.
    apples(280);
    chk("score_sat", score, 255);
    push_exp(39, 3'd1);
    frames(3);

    // Hit on the frame that would tick (count 2 == period-1): no update.
    frames(2);
    frame_start = 1'b1; collision = 2'b01;
    fs_count++; last_fs_cyc = cyc;
    step();
    frame_start = 1'b0; collision = 2'b00;
    chk("hit_state", game_state, 3);
    chk("hit_update", update, 0);
    chk("hit_dir", direction, 0);
    chk("hit_score_held", score, 255);
    step(3);

    // GAME_OVER lasts 120 frames; btn_start ignored meanwhile.
    frames(60);
    press_start();
    step();
    frames(59);
    chk("gameover_119", game_state, 3);
    frames(1);
    chk("gameover_done", game_state, 0);

    // New game, 5 apples, then reset mid-PLAY.
    press_start();
    chk("restart_score", score, 0);
    step();
    apples(5);
    chk("score_5", score, 5);
    reset = 1'b1;
    step();
    chk("midreset_state", game_state, 0);
    chk("midreset_score", score, 0);
    chk("midreset_dir", direction, 0);
    chk("midreset_update", update, 0);
    reset = 1'b0;
    step(2);

    // btn_start during PLAY: pause toggle when enabled, ignored otherwise.
    press_start();
    chk("play2_state", game_state, 1);
    step();
    frames(3);
    press_start();
`ifdef SNAKE_PAUSE_EN
    chk("pause_state", game_state, 2);
    step();
    frames(50);
    chk("pause_held", game_state, 2);
    press_start();
    chk("resume_state", game_state, 1);
`else
    chk("start_ignored", game_state, 1);
`endif
    step();
    push_exp(fs_count + 5, 3'd4);
    frames(5);
    step(4);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
